transmitter: RTL and testbench
==============================

Name: transmitter

Overview:
Serial transmitter for the serial transceiver; the counterpart of the existing receiver.
- Accepts one byte via a single-cycle handshake and shifts it out on dout as a framed async serial word: start bit 0, 8 data bits LSB first, stop bit 1.
- Bit timing comes from an internal divider on clk; no separate sample clock.
- Sits beside the receiver in the transceiver top level; dout drives the receiver's din in loopback.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, payload width; fixed at 8 in this revision.

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to send, sampled only on an accepted tx_en
tx_en  input  1  send request, accepted only when tx_status=1
tx_status  output  1  1 = idle/ready, 0 = frame in progress
tx_done  output  1  one-cycle pulse on the last cycle of the stop bit
dout  output  1  serial line, idle high

Behaviour:
- Reset on posedge clk with rst=1: state IDLE, dout=1, tx_status=1, tx_done=0, bit counter 0, divider 0, shift register 0. rst has priority over tx_en.
- Reset mid-frame aborts the frame; dout=1 from the next cycle; no tx_done.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE -> START: on posedge clk with tx_en=1 and tx_status=1, latch tx_data into the shift register.
  - Next cycle: dout=0 and tx_status=0.
- Each bit holds dout for exactly CLKS_PER_BIT cycles. Divider counts 0..CLKS_PER_BIT-1; bit advances when divider = CLKS_PER_BIT-1, and the divider wraps to 0.
- START -> DATA after one bit time.
- DATA: dout = shift_reg[0]; shift right per bit. Bit counter 0..7; after bit 7 go to STOP.
- STOP: dout=1 for one bit time.
  - On its last cycle, tx_done=1 and the state returns to IDLE.
  - tx_status=1 from the following cycle.
- Frame length: exactly 10*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
- Back-to-back: tx_en=1 on the first cycle tx_status=1 starts the next start bit immediately after. Minimum gap is one idle cycle of dout=1.
- tx_en while tx_status=0 is ignored; tx_data changes during a frame have no effect.
- Divider width is $clog2(CLKS_PER_BIT). Bit counter is 4 bits, with no overflow past 8.
- No combinational path from inputs to outputs; all outputs registered.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. dout = even parity (XOR of the 8 latched bits) for one bit time. Frame = 11*CLKS_PER_BIT cycles; tx_done moves accordingly.
- Undefined: no PARITY state; frame = 10*CLKS_PER_BIT cycles.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP)
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1
  - DATA_BITS=8
- Natural sub-module: bit_timer, the CLKS_PER_BIT divider.
  - Inputs clk, rst, run.
  - Output bit_tick, high on count CLKS_PER_BIT-1.
  - Held at 0 while run=0.

Test Plan:
1. Reset: rst=1 for 3 cycles, tx_en=1 -> dout=1, tx_status=1, tx_done=0 throughout; no frame after release.
2. Single byte, CLKS_PER_BIT=16: tx_data=8'hA5, tx_en pulse -> dout = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_status low 160 cycles; tx_done at cycle 160.
3. Back-to-back: 8'h00 then 8'hFF, tx_en held high -> two frames with exactly one idle cycle between. Loopback receiver reports 8'h00 then 8'hFF.
4. Busy ignore: 8'h3C started, then tx_en with 8'hC3 at cycle 40 -> only 8'h3C sent; tx_status stays 0 until frame end.
5. Reset mid-frame: rst at cycle 70 of 8'h55 -> dout=1 next cycle; tx_status=1; no tx_done.
6. TX_PARITY_EN with 8'h07 -> parity bit 1 before stop; frame 176 cycles at CLKS_PER_BIT=16.

Source files
------------

// File: rtl/transmitter_pkg.sv
// Shared types and constants for the serial transmitter.
// Optional feature macro: TX_PARITY_EN (adds an even-parity bit before stop).
package transmitter_pkg;

    localparam int DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/transmitter_if.sv
// Handshake and serial-line bundle between a byte source and the transmitter.
// Optional feature macro: TX_PARITY_EN (no effect on this interface).
interface transmitter_if;
    import transmitter_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_en;
    logic                 tx_status;
    logic                 tx_done;
    logic                 dout;

    modport master (
        output tx_data, tx_en,
        input  tx_status, tx_done, dout
    );

    modport slave (
        input  tx_data, tx_en,
        output tx_status, tx_done, dout
    );

endinterface

// File: rtl/transmitter_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
// Optional feature macro: TX_PARITY_EN (no effect on this module).
module transmitter_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_COUNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_q, count_d;

    // Next count: wrap at the end of each bit period, park at zero when idle.
    always_comb begin
        count_d = count_q;
        if (!run) begin
            count_d = '0;
        end else if (count_q == LAST_COUNT) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Divider register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // pre_tick lets the parent register a pulse that lands on the last cycle of a bit.
    assign bit_tick = run && (count_q == LAST_COUNT);
    assign pre_tick = run && (count_q == PRE_COUNT);

endmodule

// File: rtl/transmitter.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, stop bit, idle high.
// Optional feature macro: TX_PARITY_EN inserts an even-parity bit between data and stop.
module transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = transmitter_pkg::DATA_BITS
) (
    input  logic         clk,
    input  logic         rst,
    transmitter_if.slave bus
);
    import transmitter_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 dout_q, dout_d;
    logic                 tx_status_q, tx_status_d;
    logic                 tx_done_q, tx_done_d;
`ifdef TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic bit_tick;
    logic pre_tick;

    transmitter_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q != IDLE),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    // Frame sequencing; every output is computed one cycle ahead so it can be registered.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        tx_status_d = tx_status_q;
        tx_done_d   = 1'b0;
`ifdef TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                dout_d      = IDLE_LEVEL;
                tx_status_d = 1'b1;
                if (bus.tx_en && tx_status_q) begin
                    state_d     = START;
                    shift_d     = bus.tx_data;
                    bit_cnt_d   = 4'd0;
                    dout_d      = START_LEVEL;
                    tx_status_d = 1'b0;
`ifdef TX_PARITY_EN
                    parity_d    = ^bus.tx_data;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    dout_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 4'd0;
`ifdef TX_PARITY_EN
                        state_d   = PARITY;
                        dout_d    = parity_q;
`else
                        state_d   = STOP;
                        dout_d    = STOP_LEVEL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        dout_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
`ifdef TX_PARITY_EN
                if (bit_tick) begin
                    state_d = STOP;
                    dout_d  = STOP_LEVEL;
                end
`else
                state_d = IDLE;
                dout_d  = IDLE_LEVEL;
`endif
            end
            STOP: begin
                if (pre_tick) begin
                    tx_done_d = 1'b1;
                end
                if (bit_tick) begin
                    state_d     = IDLE;
                    dout_d      = IDLE_LEVEL;
                    tx_status_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                dout_d      = IDLE_LEVEL;
                tx_status_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            dout_q      <= IDLE_LEVEL;
            tx_status_q <= 1'b1;
            tx_done_q   <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            tx_status_q <= tx_status_d;
            tx_done_q   <= tx_done_d;
`ifdef TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.dout      = dout_q;
    assign bus.tx_status = tx_status_q;
    assign bus.tx_done   = tx_done_q;

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for the serial transmitter at CLKS_PER_BIT=16.
// Optional feature macro: TX_PARITY_EN (expected frames grow by one parity bit).
module tb_transmitter;

    localparam int CLKS = 16;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS;

    typedef struct {
        logic       rst;
        logic       tx_en;
        logic [7:0] tx_data;
        logic       exp_dout;
        logic       exp_status;
        logic       exp_done;
    } vector_t;

    logic clk;
    logic rst;
    int   check_count;
    int   error_count;

    transmitter_if bus ();

    transmitter #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected serial level for bit position idx of a frame carrying data.
    function automatic logic exp_bit(input logic [7:0] data, input int idx);
        logic [7:0] d;
        d = data;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs at a falling edge and advance to the next falling edge.
    task automatic applyStimulus(input logic r, input logic en, input logic [7:0] data);
        rst         = r;
        bus.tx_en   = en;
        bus.tx_data = data;
        @(negedge clk);
    endtask

    // Entered on the first start-bit cycle; checks every cycle of the frame against the model.
    task automatic checkFrame(input logic [7:0] data, input logic hold_en, input int poke_cycle,
                              input logic [7:0] poke_data, input int stop_after);
        logic [7:0] rx_byte;
        int         bit_idx;
        rx_byte   = 8'h00;
        bus.tx_en = hold_en;
        for (int c = 0; c < stop_after; c++) begin
            if (c > 0) @(negedge clk);
            bit_idx = c / CLKS;
            checkOutput($sformatf("frame %02h dout c%0d", data, c), 32'(bus.dout), 32'(exp_bit(data, bit_idx)));
            checkOutput($sformatf("frame %02h status c%0d", data, c), 32'(bus.tx_status), 32'd0);
            checkOutput($sformatf("frame %02h done c%0d", data, c), 32'(bus.tx_done),
                        32'(c == FRAME_CYCLES - 1));
            if (bit_idx >= 1 && bit_idx <= 8 && (c % CLKS) == CLKS / 2) rx_byte[bit_idx-1] = bus.dout;
            if (c == poke_cycle) begin
                bus.tx_en   = 1'b1;
                bus.tx_data = poke_data;
            end else if (c == poke_cycle + 1) begin
                bus.tx_en = hold_en;
            end
        end
        if (stop_after == FRAME_CYCLES) begin
            checkOutput($sformatf("loopback byte %02h", data), 32'(rx_byte), 32'(data));
            @(negedge clk);
            checkOutput($sformatf("gap %02h dout", data), 32'(bus.dout), 32'd1);
            checkOutput($sformatf("gap %02h status", data), 32'(bus.tx_status), 32'd1);
            checkOutput($sformatf("gap %02h done", data), 32'(bus.tx_done), 32'd0);
        end
    endtask

    // Start a frame from idle with a one-cycle tx_en pulse.
    task automatic startFrame(input logic [7:0] data);
        applyStimulus(1'b0, 1'b1, data);
        bus.tx_en = 1'b0;
    endtask

    initial begin
        vector_t vectors[10];
        check_count = 0;
        error_count = 0;
        rst         = 1'b1;
        bus.tx_en   = 1'b0;
        bus.tx_data = 8'h00;

        vectors[0] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        vectors[1] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        vectors[2] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        vectors[3] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
        vectors[4] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
        vectors[5] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vectors[6] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
        vectors[7] = '{1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
        vectors[8] = '{1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0};
        vectors[9] = '{1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0};

        $display("[TB] reset and handshake vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].rst, vectors[i].tx_en, vectors[i].tx_data);
            checkOutput($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vectors[i].exp_dout));
            checkOutput($sformatf("vec%0d status", i), 32'(bus.tx_status), 32'(vectors[i].exp_status));
            checkOutput($sformatf("vec%0d done", i), 32'(bus.tx_done), 32'(vectors[i].exp_done));
        end

        $display("[TB] single byte A5");
        startFrame(8'hA5);
        checkFrame(8'hA5, 1'b0, -1, 8'h00, FRAME_CYCLES);

        $display("[TB] back-to-back 00 then FF");
        applyStimulus(1'b0, 1'b1, 8'h00);
        bus.tx_data = 8'hFF;
        checkFrame(8'h00, 1'b1, -1, 8'h00, FRAME_CYCLES);
        @(negedge clk);
        checkFrame(8'hFF, 1'b0, -1, 8'h00, FRAME_CYCLES);

        $display("[TB] busy request ignored");
        startFrame(8'h3C);
        checkFrame(8'h3C, 1'b0, 40, 8'hC3, FRAME_CYCLES);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post-busy idle dout %0d", i), 32'(bus.dout), 32'd1);
            checkOutput($sformatf("post-busy idle status %0d", i), 32'(bus.tx_status), 32'd1);
        end

        $display("[TB] reset mid-frame");
        startFrame(8'h55);
        checkFrame(8'h55, 1'b0, -1, 8'h00, 71);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort dout", 32'(bus.dout), 32'd1);
        checkOutput("abort status", 32'(bus.tx_status), 32'd1);
        checkOutput("abort done", 32'(bus.tx_done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < FRAME_CYCLES; i++) begin
            @(negedge clk);
            checkOutput($sformatf("after abort dout %0d", i), 32'(bus.dout), 32'd1);
            checkOutput($sformatf("after abort done %0d", i), 32'(bus.tx_done), 32'd0);
        end

        $display("[TB] byte 07 (parity bit 1 when enabled)");
        startFrame(8'h07);
        checkFrame(8'h07, 1'b0, -1, 8'h00, FRAME_CYCLES);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
